carbon_simctl: RTL

Memory-mapped simulation-control responder for the Carbon system tops. The CPU side of a system issues byte-wide register transactions to it. It assembles the 32-bit test signature, raises a sticky `poweroff` after a two-byte key sequence, and exposes a latched free-running cycle counter. Its `signature` and `poweroff` outputs are the values the system-level benches sample at end of test.

---
 rtl/carbon_simctl_if.sv | 19 +
 rtl/carbon_simctl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/carbon_simctl_if.sv
// Byte-wide register bus between a Carbon CPU-side requester and the simulation-control responder.
interface carbon_simctl_if;
    logic       bus_req;
    logic       bus_we;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/carbon_simctl.sv
// Simulation-control responder: assembles the test signature, latches a free-running
// cycle counter and raises a sticky poweroff after a two-byte key sequence.
module carbon_simctl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  PWR_KEY0    = 8'hA5,
    parameter logic [7:0]  PWR_KEY1    = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    carbon_simctl_if.slave        bus,
    output logic [31:0]           signature,
    output logic                  sig_valid,
    output logic                  poweroff
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             lat_we;
    logic [2:0]       lat_addr;
    logic [7:0]       lat_wdata;
    logic [1:0]       ptr;
    logic [1:0]       idx;
    logic             armed;
    logic [31:0]      snap;
    logic [31:0]      cycle_cnt;
    logic [7:0]       rd_c;

    // Read value of the latched request, taken from pre-transaction state.
    always_comb begin
        rd_c = 8'h00;
        if (!lat_we) begin
            case (lat_addr)
                3'd0, 3'd1, 3'd2, 3'd3: rd_c = signature[{lat_addr[1:0], 3'b000} +: 8];
                3'd4:                   rd_c = {6'b0, ptr};
                3'd5:                   rd_c = {6'b0, armed, poweroff};
                3'd6:                   rd_c = snap[7:0];
                3'd7:                   rd_c = snap[{idx, 3'b000} +: 8];
                default:                rd_c = 8'h00;
            endcase
        end
    end

    // Transaction FSM. WAIT holds one cycle beyond the wait states so that ack and
    // read data leave registers; RESP is the single ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            lat_we        <= 1'b0;
            lat_addr      <= 3'd0;
            lat_wdata     <= 8'h00;
            bus.bus_ack   <= 1'b0;
            bus.bus_rdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bus_req) begin
                        lat_we    <= bus.bus_we;
                        lat_addr  <= bus.bus_addr;
                        lat_wdata <= bus.bus_wdata;
                        wait_cnt  <= CNT_W'(WAIT_CYCLES);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        bus.bus_ack   <= 1'b1;
                        bus.bus_rdata <= rd_c;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.bus_ack   <= 1'b0;
                    bus.bus_rdata <= 8'h00;
                    state         <= bus.bus_req ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!bus.bus_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register side effects commit on the edge that closes the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= 32'h0;
            sig_valid <= 1'b0;
            poweroff  <= 1'b0;
            ptr       <= 2'd0;
            idx       <= 2'd0;
            armed     <= 1'b0;
            snap      <= 32'h0;
        end else if (state == RESP) begin
            if (lat_addr != 3'd5) armed <= 1'b0;
            if (lat_we) begin
                case (lat_addr)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        if (!poweroff) signature[{lat_addr[1:0], 3'b000} +: 8] <= lat_wdata;
                    end
                    3'd4: begin
                        if (!poweroff) begin
                            signature[{ptr, 3'b000} +: 8] <= lat_wdata;
                            ptr <= ptr + 2'd1;
                            if (ptr == 2'd3) sig_valid <= 1'b1;
                        end
                    end
                    3'd5: begin
                        if (lat_wdata == PWR_KEY0) begin
                            armed <= 1'b1;
                        end else if (armed && (lat_wdata == PWR_KEY1)) begin
                            poweroff <= 1'b1;
                            armed    <= 1'b0;
                        end else begin
                            armed <= 1'b0;
                        end
                    end
                    3'd6: begin
                        snap <= cycle_cnt;
                        idx  <= 2'd0;
                    end
                    default: ;
                endcase
            end else if (lat_addr == 3'd7) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Free-running cycle counter; keeps counting after poweroff.
    always_ff @(posedge clk) begin
        if (rst) cycle_cnt <= 32'h0;
        else     cycle_cnt <= cycle_cnt + 32'd1;
    end

endmodule
